// File: rtl/led_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : led_share_arbiter_if
// Description : Bundles the request, grant and LED signals of the LED share
//               arbiter.
//               master : LED-producing side (drives req / req_data*, sees the
//                        grant, status and LED pins)
//               slave  : the arbiter itself
//   req        3  request per requester, level
//   req_data0  6  LED pattern from requester 0 (1 = LED on)
//   req_data1  6  LED pattern from requester 1
//   req_data2  6  LED pattern from requester 2
//   gnt        3  one-hot grant, 3'b000 when no owner
//   owner      2  index of the current owner, valid while gnt != 0
//   busy       1  display currently owned
//   tick       1  one-cycle prescaler pulse
//   led        6  board LEDs, active-low
// Revision    : 1.0 - initial release
// ============================================================================
interface led_share_arbiter_if;
  logic [2:0] req;
  logic [5:0] req_data0;
  logic [5:0] req_data1;
  logic [5:0] req_data2;
  logic [2:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       tick;
  logic [5:0] led;

  modport master (
    output req, req_data0, req_data1, req_data2,
    input  gnt, owner, busy, tick, led
  );

  modport slave (
    input  req, req_data0, req_data1, req_data2,
    output gnt, owner, busy, tick, led
  );
endinterface
`default_nettype wire

// File: rtl/led_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : led_share_arbiter
// Description : Round-robin arbiter sharing six active-low LEDs between three
//               requesters. A free-running prescaler produces the tick; an
//               owner keeps the LEDs for at least SLOT_TICKS ticks, and a
//               single blank cycle separates consecutive owners.
//   clk    in   system clock
//   reset  in   asynchronous reset, active-high
//   bus    slave side of led_share_arbiter_if (req, req_data0..2 in;
//          gnt, owner, busy, tick, led out)
// Revision    : 1.0 - initial release
// ============================================================================
module led_share_arbiter #(
  parameter int TICK_CYCLES = 27000000,
  parameter int SLOT_TICKS  = 2
) (
  input  wire logic           clk,
  input  wire logic           reset,
  led_share_arbiter_if.slave  bus
);

  localparam int                  C_TICK_W    = $clog2(TICK_CYCLES);
  localparam int                  C_SLOT_W    = $clog2(SLOT_TICKS + 1);
  localparam logic [C_TICK_W-1:0] C_TICK_LAST = C_TICK_W'(TICK_CYCLES - 1);
  localparam logic [C_SLOT_W-1:0] C_SLOT_MAX  = C_SLOT_W'(SLOT_TICKS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [2:0]          r_gnt;
  logic [2:0]          w_gnt_next;
  logic [1:0]          r_owner;
  logic [1:0]          w_owner_next;
  logic                r_busy;
  logic                w_busy_next;
  logic [5:0]          r_led;
  logic [5:0]          w_led_next;
  logic                w_load_pick;
  logic [C_TICK_W-1:0] r_tick_cnt;
  logic [C_SLOT_W-1:0] r_slot_cnt;
  logic [1:0]          r_last_owner;
  logic [1:0]          w_pick;
  logic                w_any_req;
  logic                w_tick;
  logic                w_slot_done;
  logic                w_owner_req;
  logic                w_other_req;
  logic [5:0]          w_owner_data;

  assign w_tick      = (r_tick_cnt == C_TICK_LAST);
  assign w_slot_done = (r_slot_cnt == C_SLOT_MAX);
  assign w_any_req   = |bus.req;
  // r_gnt is one-hot on the owner while in OWN, so it doubles as the owner mask
  assign w_owner_req = |(bus.req & r_gnt);
  assign w_other_req = |(bus.req & ~r_gnt);

  // Round-robin search starting just after the last owner
  always_comb begin
    w_pick = 2'd0;
    case (r_last_owner)
      2'd0: begin
        if      (bus.req[1]) w_pick = 2'd1;
        else if (bus.req[2]) w_pick = 2'd2;
        else                 w_pick = 2'd0;
      end
      2'd1: begin
        if      (bus.req[2]) w_pick = 2'd2;
        else if (bus.req[0]) w_pick = 2'd0;
        else                 w_pick = 2'd1;
      end
      default: begin
        if      (bus.req[0]) w_pick = 2'd0;
        else if (bus.req[1]) w_pick = 2'd1;
        else                 w_pick = 2'd2;
      end
    endcase
  end

  always_comb begin
    w_owner_data = 6'd0;
    case (r_owner)
      2'd0:    w_owner_data = bus.req_data0;
      2'd1:    w_owner_data = bus.req_data1;
      default: w_owner_data = bus.req_data2;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_owner_next = r_owner;
    w_busy_next  = r_busy;
    w_load_pick  = 1'b0;
    case (r_state)
      S_IDLE, S_GAP: begin
        if (w_any_req) begin
          w_state_next = S_OWN;
          w_gnt_next   = 3'b001 << w_pick;
          w_owner_next = w_pick;
          w_busy_next  = 1'b1;
          w_load_pick  = 1'b1;
        end else begin
          w_state_next = S_IDLE;
          w_gnt_next   = 3'b000;
          w_busy_next  = 1'b0;
        end
      end
      S_OWN: begin
        // Release outranks preemption; both pass through the blank cycle
        if (!w_owner_req || (w_slot_done && w_other_req)) begin
          w_state_next = S_GAP;
          w_gnt_next   = 3'b000;
          w_busy_next  = 1'b0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_gnt_next   = 3'b000;
        w_busy_next  = 1'b0;
      end
    endcase
    // The pattern is shown only while ownership continues: it appears one
    // cycle after the grant and is already blank in the GAP cycle.
    if ((r_state == S_OWN) && (w_state_next == S_OWN)) begin
      w_led_next = ~w_owner_data;
    end else begin
      w_led_next = 6'b111111;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt        <= 3'b000;
      r_owner      <= 2'd0;
      r_busy       <= 1'b0;
      r_led        <= 6'b111111;
      r_tick_cnt   <= '0;
      r_slot_cnt   <= '0;
      r_last_owner <= 2'd2;
    end else begin
      r_gnt   <= w_gnt_next;
      r_owner <= w_owner_next;
      r_busy  <= w_busy_next;
      r_led   <= w_led_next;

      if (w_tick) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + C_TICK_W'(1);
      end

      if (w_load_pick) begin
        r_slot_cnt   <= '0;
        r_last_owner <= w_pick;
      end else if ((r_state == S_OWN) && w_tick && !w_slot_done) begin
        r_slot_cnt <= r_slot_cnt + C_SLOT_W'(1);
      end
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.owner = r_owner;
  assign bus.busy  = r_busy;
  assign bus.tick  = w_tick;
  assign bus.led   = r_led;

endmodule
`default_nettype wire

// File: tb/tb_led_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_share_arbiter
// Description : Directed self-checking bench for led_share_arbiter with
//               TICK_CYCLES=4, SLOT_TICKS=2. Inputs change on the falling
//               edge, outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_share_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  led_share_arbiter_if bus ();

  led_share_arbiter #(
    .TICK_CYCLES (4),
    .SLOT_TICKS  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset   = 1'b1;
    bus.req = 3'b000;
    step();
    reset = 1'b0;
  endtask

  // 1: reset state with random inputs, then tick cadence after release
  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req       = 3'($urandom);
      bus.req_data0 = 6'($urandom);
      bus.req_data1 = 6'($urandom);
      bus.req_data2 = 6'($urandom);
      step();
      n_checks++;
      if ({bus.gnt, bus.busy, bus.led, bus.tick, bus.owner} !== {3'b000, 1'b0, 6'b111111, 1'b0, 2'd0}) begin
        n_fail++;
        $display("FAIL reset_state: gnt=%b busy=%b led=%b tick=%b owner=%0d, expected 000 0 111111 0 0",
                 bus.gnt, bus.busy, bus.led, bus.tick, bus.owner);
      end
    end
    bus.req = 3'b000;
    reset   = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_checks++;
      if (bus.tick !== ((k % 4) == 3)) begin
        n_fail++;
        $display("FAIL tick_cadence: edge %0d tick=%b, expected %b", k, bus.tick, ((k % 4) == 3));
      end
    end
  endtask

  // 2: single requester, long hold, live data update, release to IDLE
  task automatic test_single();
    int bad;
    bus.req_data0 = 6'b000101;
    bus.req       = 3'b001;
    step();
    n_checks++;
    if ({bus.gnt, bus.owner, bus.busy, bus.led} !== {3'b001, 2'd0, 1'b1, 6'b111111}) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%b owner=%0d busy=%b led=%b, expected 001 0 1 111111",
               bus.gnt, bus.owner, bus.busy, bus.led);
    end
    step();
    n_checks++;
    if (bus.led !== 6'b111010) begin
      n_fail++;
      $display("FAIL single_led: led=%b, expected 111010", bus.led);
    end
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (bus.gnt !== 3'b001) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL single_hold: %0d cycles without gnt=001, expected 0", bad);
    end
    bus.req_data0 = 6'b110000;
    step();
    n_checks++;
    if (bus.led !== 6'b001111) begin
      n_fail++;
      $display("FAIL single_data_change: led=%b, expected 001111", bus.led);
    end
    bus.req = 3'b000;
    step();
    n_checks++;
    if ({bus.gnt, bus.busy, bus.led} !== {3'b000, 1'b0, 6'b111111}) begin
      n_fail++;
      $display("FAIL single_release_gap: gnt=%b busy=%b led=%b, expected 000 0 111111",
               bus.gnt, bus.busy, bus.led);
    end
    step();
    n_checks++;
    if ({bus.gnt, bus.busy} !== {3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL single_idle: gnt=%b busy=%b, expected 000 0", bus.gnt, bus.busy);
    end
  endtask

  // 3: all three request from IDLE after reset -> 0,1,2,0 with gaps
  task automatic test_round_robin();
    logic [2:0] order [4];
    logic [5:0] pats  [3];
    int         cnt;
    order = '{3'b001, 3'b010, 3'b100, 3'b001};
    pats  = '{6'b000001, 6'b000010, 6'b000100};
    apply_reset();
    bus.req_data0 = pats[0];
    bus.req_data1 = pats[1];
    bus.req_data2 = pats[2];
    bus.req       = 3'b111;
    step();
    n_checks++;
    if (bus.gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL rr_first: gnt=%b, expected 001", bus.gnt);
    end
    for (int i = 0; i < 3; i++) begin
      cnt = 1;
      for (int c = 0; c < 20; c++) begin
        step();
        if (bus.gnt !== order[i]) break;
        if (c == 0) begin
          n_checks++;
          if (bus.led !== ~pats[i]) begin
            n_fail++;
            $display("FAIL rr_led: owner slot %0d led=%b, expected %b", i, bus.led, ~pats[i]);
          end
        end
        cnt++;
      end
      n_checks++;
      if ({bus.gnt, bus.busy, bus.led} !== {3'b000, 1'b0, 6'b111111}) begin
        n_fail++;
        $display("FAIL rr_gap: slot %0d gnt=%b busy=%b led=%b, expected 000 0 111111",
                 i, bus.gnt, bus.busy, bus.led);
      end
      n_checks++;
      if (cnt < 6 || cnt > 9) begin
        n_fail++;
        $display("FAIL rr_slot_len: slot %0d lasted %0d cycles, expected 6..9", i, cnt);
      end
      step();
      n_checks++;
      if (bus.gnt !== order[i+1]) begin
        n_fail++;
        $display("FAIL rr_next: after slot %0d gnt=%b, expected %b", i, bus.gnt, order[i+1]);
      end
    end
    bus.req = 3'b000;
    step();
    step();
  endtask

  // 4: owner 1 releases mid-slot with 2 pending, then 2 releases with none pending
  task automatic test_release();
    bus.req = 3'b010;
    step();
    n_checks++;
    if (bus.gnt !== 3'b010) begin
      n_fail++;
      $display("FAIL release_grant1: gnt=%b, expected 010", bus.gnt);
    end
    step();
    bus.req = 3'b110;
    step();
    bus.req = 3'b100;
    step();
    n_checks++;
    if ({bus.gnt, bus.busy, bus.led} !== {3'b000, 1'b0, 6'b111111}) begin
      n_fail++;
      $display("FAIL release_gap: gnt=%b busy=%b led=%b, expected 000 0 111111",
               bus.gnt, bus.busy, bus.led);
    end
    step();
    n_checks++;
    if ({bus.gnt, bus.owner} !== {3'b100, 2'd2}) begin
      n_fail++;
      $display("FAIL release_regrant: gnt=%b owner=%0d, expected 100 2", bus.gnt, bus.owner);
    end
    bus.req = 3'b000;
    step();
    n_checks++;
    if ({bus.gnt, bus.led} !== {3'b000, 6'b111111}) begin
      n_fail++;
      $display("FAIL release_gap2: gnt=%b led=%b, expected 000 111111", bus.gnt, bus.led);
    end
    step();
    step();
    n_checks++;
    if ({bus.gnt, bus.busy, bus.led} !== {3'b000, 1'b0, 6'b111111}) begin
      n_fail++;
      $display("FAIL release_idle: gnt=%b busy=%b led=%b, expected 000 0 111111",
               bus.gnt, bus.busy, bus.led);
    end
  endtask

  // 5: asynchronous reset between edges while owning
  task automatic test_async_reset();
    bus.req_data0 = 6'b101010;
    bus.req       = 3'b001;
    step();
    step();
    step();
    n_checks++;
    if ({bus.gnt, bus.led} !== {3'b001, 6'b010101}) begin
      n_fail++;
      $display("FAIL async_pre: gnt=%b led=%b, expected 001 010101", bus.gnt, bus.led);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.gnt, bus.busy, bus.led} !== {3'b000, 1'b0, 6'b111111}) begin
      n_fail++;
      $display("FAIL async_reset_immediate: gnt=%b busy=%b led=%b, expected 000 0 111111",
               bus.gnt, bus.busy, bus.led);
    end
    @(negedge clk);
    bus.req = 3'b110;
    reset   = 1'b0;
    step();
    n_checks++;
    if ({bus.gnt, bus.owner} !== {3'b010, 2'd1}) begin
      n_fail++;
      $display("FAIL async_reset_restart: gnt=%b owner=%0d, expected 010 1", bus.gnt, bus.owner);
    end
    bus.req = 3'b000;
    step();
    step();
  endtask

  // 6: preemption 0 -> 1, then regrant of 1 only when it is the sole requester
  task automatic test_preempt_regrant();
    apply_reset();
    bus.req = 3'b001;
    step();
    n_checks++;
    if (bus.gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL preempt_start: gnt=%b, expected 001", bus.gnt);
    end
    bus.req = 3'b011;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.gnt !== 3'b001) break;
    end
    n_checks++;
    if (bus.gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL preempt_gap: gnt=%b, expected 000", bus.gnt);
    end
    step();
    n_checks++;
    if (bus.gnt !== 3'b010) begin
      n_fail++;
      $display("FAIL preempt_to_1: gnt=%b, expected 010", bus.gnt);
    end
    bus.req = 3'b000;
    step();
    n_checks++;
    if (bus.gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL regrant_gap_a: gnt=%b, expected 000", bus.gnt);
    end
    bus.req = 3'b010;
    step();
    n_checks++;
    if (bus.gnt !== 3'b010) begin
      n_fail++;
      $display("FAIL regrant_sole: gnt=%b, expected 010", bus.gnt);
    end
    bus.req = 3'b001;
    step();
    n_checks++;
    if (bus.gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL regrant_gap_b: gnt=%b, expected 000", bus.gnt);
    end
    bus.req = 3'b011;
    step();
    n_checks++;
    if (bus.gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL regrant_other_wins: gnt=%b, expected 001", bus.gnt);
    end
    bus.req = 3'b000;
    step();
    step();
  endtask

  initial begin
    clk           = 1'b0;
    reset         = 1'b1;
    n_checks      = 0;
    n_fail        = 0;
    bus.req       = 3'b000;
    bus.req_data0 = 6'd0;
    bus.req_data1 = 6'd0;
    bus.req_data2 = 6'd0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_release();
    test_async_reset();
    test_preempt_regrant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
